lsb_param: RTL and testbench

LSB_PARAM -- requirements
Module: lsb_param

---
 rtl/lsb_param.sv | 215 +++++++++++++++++++++
 tb/tb_lsb_param.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_param.sv
// In-order load/store buffer: circular queue of memory ops that snoop the CDB for
// pending operands and issue one memory transaction at a time to a req/gnt/done port.
module lsb_param #(
  parameter int DEPTH   = 8,
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic [ROB_W-1:0]           head_rob_id,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic                       enq_is_store,
  input  logic [2:0]                 enq_op,
  input  logic [31:0]                enq_imm,
  input  logic [31:0]                enq_v1,
  input  logic [31:0]                enq_v2,
  input  logic                       enq_dep1,
  input  logic                       enq_dep2,
  input  logic [ROB_W-1:0]           enq_q1,
  input  logic [ROB_W-1:0]           enq_q2,
  input  logic [ROB_W-1:0]           enq_rob_id,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]      cdb_value,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [2:0]                 mem_op,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_gnt,
  input  logic                       mem_done,
  input  logic [31:0]                mem_rdata,
  output logic                       out_valid,
  output logic [ROB_W-1:0]           out_rob_id,
  output logic [31:0]                out_value,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic             is_store;
    logic [2:0]       op;
    logic [31:0]      imm;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic             dep1;
    logic             dep2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic [ROB_W-1:0] rob;
  } ent_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t         state_q, state_d;
  ent_t           ent_q [DEPTH];
  ent_t           ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PW:0]    cnt_q, cnt_d;
  ent_t           enq_res, cand;
  logic           enq_fire, deq, issue, cand_ok, done_out, out_vld_q;
  logic [ROB_W-1:0] cur_rob;

  // Descending scan so the lowest-numbered matching channel is the one that sticks.
  function automatic ent_t resolve(input ent_t e);
    ent_t r;
    r = e;
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (cdb_valid[k] && e.dep1 && cdb_rob_id[k*ROB_W +: ROB_W] == e.q1) begin
        r.dep1 = 1'b0;
        r.v1   = cdb_value[k*32 +: 32];
      end
      if (cdb_valid[k] && e.dep2 && cdb_rob_id[k*ROB_W +: ROB_W] == e.q2) begin
        r.dep2 = 1'b0;
        r.v2   = cdb_value[k*32 +: 32];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] d);
    case (op[1:0])
      2'd0:    return op[2] ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'd1:    return op[2] ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign count     = cnt_q;
  assign full      = (cnt_q == (PW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign enq_ready = !full;
  assign out_valid = out_vld_q && rdy;

  assign enq_fire = enq_valid && !full && rdy && !flush;
  assign deq      = rdy && !flush && (state_q == S_REQ) && mem_gnt;
  assign done_out = rdy && !flush && (state_q == S_WAIT) && mem_done;

  // An empty queue lets the incoming op issue straight away, giving next-cycle mem_req.
  always_comb begin
    enq_res = resolve('{is_store: enq_is_store, op: enq_op, imm: enq_imm, v1: enq_v1,
                        v2: enq_v2, dep1: enq_dep1, dep2: enq_dep2, q1: enq_q1,
                        q2: enq_q2, rob: enq_rob_id});
    cand    = (cnt_q == '0) ? enq_res : ent_q[head_q];
    cand_ok = ((cnt_q == '0) ? enq_fire : vld_q[head_q]) && !cand.dep1 && !cand.dep2 &&
              (!cand.is_store || cand.rob == head_rob_id);
  end

  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = vld_q[i] ? resolve(ent_q[i]) : ent_q[i];
      if (enq_fire && tail_q == PW'(i)) ent_d[i] = enq_res;
    end
    if (enq_fire) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + 1'b1;
    end
    if (deq) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    case ({enq_fire, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      vld_d  = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (rdy) begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A done coinciding with flush in WAIT closes the transaction; nothing left to drain.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (rdy) begin
      case (state_q)
        S_IDLE:  if (!flush && cand_ok) begin
                   state_d = S_REQ;
                   issue   = 1'b1;
                 end
        S_REQ:   if (flush)        state_d = mem_gnt ? S_DRAIN : S_IDLE;
                 else if (mem_gnt) state_d = S_WAIT;
        S_WAIT:  if (mem_done)     state_d = S_IDLE;
                 else if (flush)   state_d = S_DRAIN;
        S_DRAIN: if (mem_done)     state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_op     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cur_rob    <= '0;
      out_vld_q  <= 1'b0;
      out_rob_id <= '0;
      out_value  <= '0;
    end else if (rdy) begin
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= cand.is_store;
        mem_op    <= cand.op;
        mem_addr  <= cand.v1 + cand.imm;
        mem_wdata <= cand.v2;
        cur_rob   <= cand.rob;
      end else if (state_q == S_REQ && (mem_gnt || flush)) begin
        mem_req <= 1'b0;
      end
      out_vld_q <= done_out;
      if (done_out) begin
        out_rob_id <= cur_rob;
        out_value  <= mem_we ? 32'd0 : ext(mem_op, mem_rdata);
      end
    end
  end
endmodule

// File: tb/tb_lsb_param.sv
// Self-checking bench for lsb_param: directed scenarios, then randomized traffic
// against a transaction-level queue model and an auto-responding memory.
module tb_lsb_param;
  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic [3:0]  head_rob_id;
  logic        enq_valid, enq_ready, enq_is_store, enq_dep1, enq_dep2;
  logic [2:0]  enq_op;
  logic [31:0] enq_imm, enq_v1, enq_v2;
  logic [3:0]  enq_q1, enq_q2, enq_rob_id;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value;
  logic        mem_req, mem_we, mem_gnt, mem_done;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        out_valid;
  logic [3:0]  out_rob_id;
  logic [31:0] out_value;
  logic [3:0]  count;
  logic        full, empty;

  lsb_param dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .head_rob_id(head_rob_id),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_is_store(enq_is_store),
    .enq_op(enq_op), .enq_imm(enq_imm), .enq_v1(enq_v1), .enq_v2(enq_v2),
    .enq_dep1(enq_dep1), .enq_dep2(enq_dep2), .enq_q1(enq_q1), .enq_q2(enq_q2),
    .enq_rob_id(enq_rob_id), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_value(cdb_value), .mem_req(mem_req), .mem_we(mem_we), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_rob_id(out_rob_id),
    .out_value(out_value), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rob;
  } txn_t;
  typedef struct {
    logic [3:0]  rob;
    logic [31:0] val;
  } out_t;

  int          total = 0, bad = 0;
  txn_t        model_q[$];
  out_t        outq[$];
  txn_t        cur;
  out_t        o;
  logic [31:0] tagval [16];
  bit          auto_mem = 1'b0, mon_en = 1'b0, busy = 1'b0;
  int          dly = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Loaded value as the architecture defines it: keep 1/2/4 bytes, then sign- or zero-extend.
  function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [31:0] d);
    int     nb;
    longint m, v;
    nb = (op[1:0] == 2'd0) ? 8 : (op[1:0] == 2'd1) ? 16 : 32;
    m  = (longint'(1) << nb) - 1;
    v  = longint'(d) & m;
    if (!op[2] && nb < 32 && v >= (longint'(1) << (nb-1))) v = v - (longint'(1) << nb);
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic st, input logic [2:0] op, input logic [31:0] imm,
                     input logic [31:0] v1, input logic [31:0] v2, input logic d1,
                     input logic [3:0] q1, input logic d2, input logic [3:0] q2,
                     input logic [3:0] rob);
    enq_is_store = st; enq_op = op; enq_imm = imm; enq_v1 = v1; enq_v2 = v2;
    enq_dep1 = d1; enq_q1 = q1; enq_dep2 = d2; enq_q2 = q2; enq_rob_id = rob;
    enq_valid = 1'b1;
    step();
    enq_valid = 1'b0;
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
  endtask

  task automatic done(input logic [31:0] rd);
    mem_done = 1'b1;
    mem_rdata = rd;
    step();
    mem_done = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int lim);
    int n = 0;
    while (!mem_req && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(mem_req), 32'd1);
  endtask

  // Memory model used during the randomized phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_gnt  = 1'b0;
      mem_done = 1'b0;
      if (busy) begin
        if (dly == 0) begin
          mem_done  = 1'b1;
          mem_rdata = $urandom;
          busy      = 1'b0;
        end else dly--;
      end else if (mem_req && $urandom_range(1) == 1) begin
        mem_gnt = 1'b1;
        busy    = 1'b1;
        dly     = $urandom_range(2);
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    if (mem_req && mem_gnt) begin
      if (model_q.size() == 0) chk("req_unexp", 32'(model_q.size()), 32'd1);
      else begin
        cur = model_q.pop_front();
        chk("r_addr", mem_addr, cur.addr);
        chk("r_we", 32'(mem_we), 32'(cur.st));
        chk("r_op", 32'(mem_op), 32'(cur.op));
        chk("r_wdata", mem_wdata, cur.wdata);
      end
    end
    if (mem_done) begin
      o.rob = cur.rob;
      o.val = cur.st ? 32'd0 : ref_ext(cur.op, mem_rdata);
      outq.push_back(o);
    end
    if (out_valid) begin
      if (outq.size() == 0) chk("out_unexp", 32'(outq.size()), 32'd1);
      else begin
        o = outq.pop_front();
        chk("r_orob", 32'(out_rob_id), 32'(o.rob));
        chk("r_oval", out_value, o.val);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, cyc;
    txn_t e;
    logic st, d1, d2;
    logic [2:0] op;
    logic [31:0] v1, v2, imm;
    logic [3:0] q1, q2, rob, tg;

    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; head_rob_id = '0;
    enq_valid = 1'b0; enq_is_store = 1'b0; enq_op = '0; enq_imm = '0; enq_v1 = '0;
    enq_v2 = '0; enq_dep1 = 1'b0; enq_dep2 = 1'b0; enq_q1 = '0; enq_q2 = '0;
    enq_rob_id = '0; cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
    mem_gnt = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_oval", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_flags", 32'({empty, full, enq_ready}), 32'b101);
    rst_n = 1'b1;
    step();

    // LW with next-cycle issue
    enq(1'b0, 3'b010, 32'd4, 32'h100, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    chk("lw_req", 32'(mem_req), 32'd1);
    chk("lw_addr", mem_addr, 32'h104);
    chk("lw_weop", 32'({mem_we, mem_op}), 32'b0010);
    grant();
    chk("lw_req_drop", 32'(mem_req), 32'd0);
    chk("lw_cnt", 32'(count), 32'd0);
    done(32'hDEADBEEF);
    chk("lw_ov", 32'(out_valid), 32'd1);
    chk("lw_orob", 32'(out_rob_id), 32'd3);
    chk("lw_oval", out_value, 32'hDEADBEEF);
    step();
    chk("lw_ov_pulse", 32'(out_valid), 32'd0);

    // byte loads, unsigned then signed
    enq(1'b0, 3'b100, 32'd0, 32'h20, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    grant(); done(32'h80);
    chk("lbu_val", out_value, 32'h00000080);
    step();
    enq(1'b0, 3'b000, 32'd0, 32'h20, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
    grant(); done(32'h80);
    chk("lb_val", out_value, 32'hFFFFFF80);
    step();

    // store waits for its RoB slot to reach the head
    head_rob_id = 4'd4;
    enq(1'b1, 3'b010, 32'd0, 32'h40, 32'h1234, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    chk("st_hold0", 32'(mem_req), 32'd0);
    step();
    chk("st_hold1", 32'(mem_req), 32'd0);
    step();
    chk("st_hold2", 32'(mem_req), 32'd0);
    head_rob_id = 4'd5;
    step();
    chk("st_req", 32'(mem_req), 32'd1);
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_wdata", mem_wdata, 32'h1234);
    grant(); done(32'hFFFFFFFF);
    chk("st_orob", 32'(out_rob_id), 32'd5);
    chk("st_oval", out_value, 32'd0);
    step();
    head_rob_id = 4'd0;

    // operand forwarded from the CDB in the enqueue cycle
    cdb_valid = 2'b10; cdb_rob_id = {4'd2, 4'd0}; cdb_value = {32'h200, 32'h0};
    enq(1'b0, 3'b010, 32'h10, 32'hBAD, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd6);
    cdb_valid = '0;
    chk("fwd_req", 32'(mem_req), 32'd1);
    chk("fwd_addr", mem_addr, 32'h210);
    grant(); done(32'd1); step();

    // two channels carry the same tag: channel 0 wins
    cdb_valid = 2'b11; cdb_rob_id = {4'd6, 4'd6}; cdb_value = {32'h700, 32'h300};
    enq(1'b0, 3'b010, 32'h10, 32'hBAD, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 4'd7);
    cdb_valid = '0;
    chk("prio_addr", mem_addr, 32'h310);
    grant(); done(32'd1); step();

    // pending entry picks up a later broadcast
    enq(1'b0, 3'b010, 32'h8, 32'hBAD, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, 4'd8);
    step();
    chk("snp_wait", 32'(mem_req), 32'd0);
    cdb_valid = 2'b10; cdb_rob_id = {4'd9, 4'd0}; cdb_value = {32'h500, 32'h0};
    step();
    cdb_valid = '0;
    wait_req("snp_req", 4);
    chk("snp_addr", mem_addr, 32'h508);
    grant(); done(32'd1); step();

    // fill, overflow attempt, pop+push, flush out of REQ
    for (int i = 0; i < 8; i++)
      enq(1'b0, 3'b010, 32'(i*4), 32'hBAD, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'(i));
    chk("full_cnt", 32'(count), 32'd8);
    chk("full_flags", 32'({full, enq_ready, empty}), 32'b100);
    enq(1'b0, 3'b010, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    chk("full_block", 32'(count), 32'd8);
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd11}; cdb_value = {32'h0, 32'h1000};
    step();
    cdb_valid = '0;
    wait_req("full_req0", 4);
    chk("full_addr0", mem_addr, 32'h1000);
    grant();
    chk("pop_cnt", 32'(count), 32'd7);
    done(32'd0);
    wait_req("full_req1", 4);
    chk("full_addr1", mem_addr, 32'h1004);
    mem_gnt = 1'b1;
    enq(1'b0, 3'b010, 32'd0, 32'd0, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'd8);
    mem_gnt = 1'b0;
    chk("pushpop_cnt", 32'(count), 32'd7);
    enq(1'b0, 3'b010, 32'd0, 32'd0, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'd9);
    chk("refill_full", 32'({full, count}), 32'b11000);
    done(32'd0);
    wait_req("full_req2", 4);
    chk("full_addr2", mem_addr, 32'h1008);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_req_drop", 32'(mem_req), 32'd0);
    chk("fl_cnt", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    step();
    chk("fl_idle", 32'(mem_req), 32'd0);

    // flush while waiting for data; the stale response is swallowed
    enq(1'b0, 3'b010, 32'd0, 32'h300, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    enq(1'b0, 3'b010, 32'd0, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd5);
    grant();
    chk("fw_cnt1", 32'(count), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fw_cnt0", 32'(count), 32'd0);
    enq(1'b0, 3'b010, 32'd0, 32'h600, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    chk("dr_cnt", 32'(count), 32'd1);
    chk("dr_noreq", 32'(mem_req), 32'd0);
    done(32'h55);
    chk("dr_noout", 32'(out_valid), 32'd0);
    step();
    chk("dr_req", 32'(mem_req), 32'd1);
    chk("dr_addr", mem_addr, 32'h600);
    grant(); done(32'h12345678);
    chk("dr_ov", 32'(out_valid), 32'd1);
    chk("dr_orob", 32'(out_rob_id), 32'd7);
    chk("dr_oval", out_value, 32'h12345678);
    step();

    // rdy low freezes everything, including a pending output pulse
    enq(1'b0, 3'b010, 32'd0, 32'h700, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    rdy = 1'b0;
    mem_gnt = 1'b1;
    step(); step();
    chk("frz_req", 32'(mem_req), 32'd1);
    chk("frz_addr", mem_addr, 32'h700);
    chk("frz_cnt", 32'(count), 32'd1);
    rdy = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("frz_gnt", 32'(count), 32'd0);
    done(32'hAB);
    rdy = 1'b0;
    #1;
    chk("frz_ov0", 32'(out_valid), 32'd0);
    step();
    chk("frz_ov1", 32'(out_valid), 32'd0);
    rdy = 1'b1;
    #1;
    chk("frz_ov2", 32'(out_valid), 32'd1);
    chk("frz_oval", out_value, 32'hAB);
    step();
    chk("frz_ov3", 32'(out_valid), 32'd0);

    // reset in the middle of a transaction
    enq(1'b0, 3'b010, 32'd0, 32'h800, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
    enq(1'b0, 3'b010, 32'd0, 32'd0, 32'd0, 1'b1, 4'd13, 1'b0, 4'd0, 4'd11);
    grant();
    rst_n = 1'b0;
    #1;
    chk("mrst_cnt", 32'(count), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    done(32'h99);
    chk("mrst_noout", 32'(out_valid), 32'd0);
    chk("mrst_noreq", 32'(mem_req), 32'd0);

    // randomized traffic
    for (int t = 0; t < 16; t++) tagval[t] = $urandom;
    auto_mem = 1'b1;
    mon_en   = 1'b1;
    sent = 0;
    cyc  = 0;
    while ((sent < 150 || model_q.size() != 0 || outq.size() != 0 || busy) && cyc < 20000) begin
      for (int k = 0; k < 2; k++) begin
        cdb_valid[k] = 1'($urandom_range(1));
        tg = 4'($urandom);
        cdb_rob_id[k*4 +: 4]   = tg;
        cdb_value[k*32 +: 32]  = tagval[tg];
      end
      enq_valid = 1'b0;
      if (sent < 150 && enq_ready && $urandom_range(2) != 0) begin
        st  = ($urandom_range(3) == 0);
        op  = {1'($urandom_range(1)), 2'($urandom_range(2))};
        imm = $urandom; v1 = $urandom; v2 = $urandom;
        d1  = ($urandom_range(2) == 0); d2 = ($urandom_range(3) == 0);
        q1  = 4'($urandom); q2 = 4'($urandom); rob = 4'($urandom);
        enq_is_store = st; enq_op = op; enq_imm = imm; enq_v1 = v1; enq_v2 = v2;
        enq_dep1 = d1; enq_q1 = q1; enq_dep2 = d2; enq_q2 = q2; enq_rob_id = rob;
        enq_valid = 1'b1;
        e.st    = st;
        e.op    = op;
        e.addr  = (d1 ? tagval[q1] : v1) + imm;
        e.wdata = d2 ? tagval[q2] : v2;
        e.rob   = rob;
        model_q.push_back(e);
        sent++;
      end
      head_rob_id = (model_q.size() != 0) ? model_q[0].rob : 4'd0;
      step();
      cyc++;
    end
    enq_valid = 1'b0;
    cdb_valid = '0;
    chk("rand_drain", 32'(cyc < 20000), 32'd1);
    chk("rand_empty", 32'(empty), 32'd1);
    step();
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
